// File: rtl/pkt_pkg.sv
// Shared constants, header type and CRC8 helpers for the packet builder.
// No latency of its own: pure definitions and combinational functions.
// No flow control: imported by crc8_unit and pkt_builder.
package pkt_pkg;

    localparam logic [3:0] OP0 = 4'd0;
    localparam logic [3:0] OP1 = 4'd1;
    localparam logic [3:0] OP2 = 4'd2;

    localparam logic [7:0] CRC_POLY = 8'h07;
    localparam logic [7:0] CRC_INIT = 8'h00;

    localparam int MAX_PKT_BYTES = 19;
    localparam int MAX_PKT_WORDS = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ADDR,
        S_RD_DATA,
        S_CRC,
        S_WR_ADDR,
        S_WR_DATA,
        S_WR_RESP
    } state_t;

    typedef struct packed {
        logic [3:0] sel;
        logic [3:0] cnt;
    } hdr_t;

    // MSB-first, unreflected, no final XOR.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++)
            c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
        return c;
    endfunction

    function automatic logic [2:0] lanes_per_beat(input logic [3:0] sel);
        case (sel)
            OP0:     return 3'd1;
            OP1:     return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [4:0] payload_len(input logic [3:0] sel, input logic [3:0] cnt);
        case (sel)
            OP0:     return {3'b0, cnt[3:2]} + 5'd1;
            OP1:     return {2'b0, cnt[3:2], 1'b0} + (cnt[1] ? 5'd2 : ({4'b0, cnt[0]} + 5'd1));
            default: return {1'b0, cnt} + 5'd1;
        endcase
    endfunction

endpackage

// File: rtl/crc8_unit.sv
// Serial byte-wide CRC8 register (poly 0x07, init 0x00).
// Latency: crc reflects a byte one cycle after it is presented with en.
// No backpressure: a byte is absorbed on every cycle en is high.
module crc8_unit
    import pkt_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       en,
    input  logic [7:0] din,
    output logic [7:0] crc
);

    always_ff @(posedge clk) begin
        if (reset || clear)
            crc <= CRC_INIT;
        else if (en)
            crc <= crc8_byte(crc, din);
    end

endmodule

// File: rtl/pkt_builder.sv
// Reads input words, extracts payload, frames it with header + CRC8 and writes it out.
// Latency (zero-wait slaves): 1+1+(arlen+1)+(L+2)+1+(awlen+1)+1 cycles start to done.
// Backpressure: holds arvalid/awvalid/wvalid with stable payload until the slave accepts.
module pkt_builder
    import pkt_pkg::*;
#(
    parameter logic [31:0] IN_BASE  = 32'h0000_0000,
    parameter logic [31:0] OUT_BASE = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  byte_cnt,
    input  logic [3:0]  data_sel,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] araddr,
    output logic [3:0]  arlen,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    input  logic        rlast,
    output logic        rready,
    output logic [31:0] awaddr,
    output logic [3:0]  awlen,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic        wvalid,
    output logic        wlast,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready
);

    state_t     state;
    logic [3:0] bc_q;
    logic [3:0] sel_q;
    logic [4:0] len_q;
    logic [4:0] len_p2;
    logic [1:0] rbeat;
    logic       drain;
    logic [4:0] ptr;
    logic [4:0] crc_idx;
    logic [2:0] wbeat;
    logic [7:0] pbuf [MAX_PKT_BYTES];
    logic [7:0] crc_val;
    logic       start_ok;
    logic       r_hs;
    logic [2:0] n_lanes;
    logic [3:0] lane_keep;
    logic [2:0] lane_cnt;

    assign start_ok = (state == S_IDLE) && start;
    assign r_hs     = (state == S_RD_DATA) && rvalid;
    assign busy     = (state != S_IDLE);
    assign rready   = (state == S_RD_DATA);
    assign bready   = (state == S_WR_RESP);
    assign len_p2   = len_q + 5'd2;
    assign n_lanes  = lanes_per_beat(sel_q);

    crc8_unit u_crc (
        .clk   (clk),
        .reset (reset),
        .clear (start_ok),
        .en    (state == S_CRC),
        .din   (pbuf[crc_idx]),
        .crc   (crc_val)
    );

    // Lanes kept this beat form a prefix; the final beat also trims past byte_cnt.
    always_comb begin
        lane_keep = '0;
        lane_cnt  = '0;
        for (int k = 0; k < 4; k++) begin
            if ((3'(k) < n_lanes) && ((rbeat != bc_q[3:2]) || ({rbeat, 2'(k)} <= bc_q))) begin
                lane_keep[k] = 1'b1;
                lane_cnt     = lane_cnt + 3'd1;
            end
        end
    end

    // The CRC byte lives in the CRC register; everything past it reads as zero padding.
    function automatic logic [7:0] pkt_byte(input logic [4:0] idx);
        if (idx == len_p2)
            return crc_val;
        if (idx >= 5'(MAX_PKT_BYTES))
            return 8'h00;
        return pbuf[idx];
    endfunction

    function automatic logic [31:0] pkt_word(input logic [2:0] w);
        logic [31:0] d;
        d = '0;
        for (int k = 0; k < 4; k++)
            d[8*k +: 8] = pkt_byte({w, 2'(k)});
        return d;
    endfunction

    always_ff @(posedge clk) begin
        if (start_ok) begin
            for (int i = 0; i < MAX_PKT_BYTES; i++)
                pbuf[i] <= 8'h00;
            pbuf[0] <= hdr_t'{sel: data_sel, cnt: byte_cnt};
            pbuf[1] <= {3'b0, payload_len(data_sel, byte_cnt)};
        end else if (r_hs && !drain) begin
            for (int k = 0; k < 4; k++)
                if (lane_keep[k])
                    pbuf[ptr + 5'(k)] <= rdata[8*k +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            bc_q    <= '0;
            sel_q   <= '0;
            len_q   <= '0;
            rbeat   <= '0;
            drain   <= 1'b0;
            ptr     <= '0;
            crc_idx <= '0;
            wbeat   <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
            araddr  <= '0;
            arlen   <= '0;
            arvalid <= 1'b0;
            awaddr  <= '0;
            awlen   <= '0;
            awvalid <= 1'b0;
            wdata   <= '0;
            wvalid  <= 1'b0;
            wlast   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_RD_ADDR;
                        bc_q    <= byte_cnt;
                        sel_q   <= data_sel;
                        len_q   <= payload_len(data_sel, byte_cnt);
                        err     <= 1'b0;
                        rbeat   <= '0;
                        drain   <= 1'b0;
                        ptr     <= 5'd2;
                        araddr  <= IN_BASE;
                        arlen   <= {2'b0, byte_cnt[3:2]};
                        arvalid <= 1'b1;
                    end
                end
                S_RD_ADDR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        state   <= S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (rvalid) begin
                        if (drain) begin
                            if (rlast) begin
                                drain   <= 1'b0;
                                crc_idx <= '0;
                                state   <= S_CRC;
                            end
                        end else begin
                            ptr <= ptr + {2'b0, lane_cnt};
                            if (rbeat == bc_q[3:2]) begin
                                if (rlast) begin
                                    crc_idx <= '0;
                                    state   <= S_CRC;
                                end else begin
                                    err   <= 1'b1;
                                    drain <= 1'b1;
                                end
                            end else begin
                                if (rlast)
                                    err <= 1'b1;
                                rbeat <= rbeat + 2'd1;
                            end
                        end
                    end
                end
                S_CRC: begin
                    crc_idx <= crc_idx + 5'd1;
                    if (crc_idx == len_q + 5'd1) begin
                        state   <= S_WR_ADDR;
                        awaddr  <= OUT_BASE;
                        awlen   <= {1'b0, len_p2[4:2]};
                        awvalid <= 1'b1;
                    end
                end
                S_WR_ADDR: begin
                    if (awready) begin
                        awvalid <= 1'b0;
                        state   <= S_WR_DATA;
                        wbeat   <= '0;
                        wdata   <= pkt_word(3'd0);
                        wlast   <= (awlen == 4'd0);
                        wvalid  <= 1'b1;
                    end
                end
                S_WR_DATA: begin
                    if (wready) begin
                        if (wlast) begin
                            wvalid <= 1'b0;
                            wlast  <= 1'b0;
                            state  <= S_WR_RESP;
                        end else begin
                            wbeat <= wbeat + 3'd1;
                            wdata <= pkt_word(wbeat + 3'd1);
                            wlast <= (({1'b0, wbeat} + 4'd1) == awlen);
                        end
                    end
                end
                S_WR_RESP: begin
                    if (bvalid) begin
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
